// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus: raw pins and flag clears in, clean vector,
// edge pulses and sticky change flags out.
interface sw_debounce_if #(
   parameter int unsigned WIDTH = 16
);
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_o;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;
   logic [WIDTH-1:0] chg_flag;
   logic [WIDTH-1:0] chg_clr;
   logic             chg_any;

   modport master (
      output sw_raw,
      output chg_clr,
      input  sw_o,
      input  sw_rise,
      input  sw_fall,
      input  chg_flag,
      input  chg_any
   );

   modport slave (
      input  sw_raw,
      input  chg_clr,
      output sw_o,
      output sw_rise,
      output sw_fall,
      output chg_flag,
      output chg_any
   );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit two-flop synchroniser and stability-window debouncer for the board
// slide switches, with registered rise/fall pulses and sticky change flags.
module sw_debounce #(
   parameter int unsigned WIDTH         = 16,
   parameter int unsigned STABLE_CYCLES = 1000000,
   parameter int unsigned CNT_W         = 20
) (
   input  logic          clk,
   input  logic          rst,
   sw_debounce_if.slave  bus
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] sw_q;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;
   logic [WIDTH-1:0] flag_q;
   logic [WIDTH-1:0] upd;
   logic [CNT_W-1:0] cnt [WIDTH];

   // A bit is accepted on the edge where its mismatch has already persisted
   // for STABLE_CYCLES-1 edges; the counter therefore never reaches the wrap.
   always_comb begin
      upd = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         upd[i] = (sync2[i] != sw_q[i]) && (cnt[i] == CNT_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         sw_q   <= '0;
         rise_q <= '0;
         fall_q <= '0;
         flag_q <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1  <= bus.sw_raw;
         sync2  <= sync1;
         sw_q   <= (sw_q & ~upd) | (sync2 & upd);
         rise_q <= upd & sync2;
         fall_q <= upd & ~sync2;
         // Set has priority over a clear on the same edge.
         flag_q <= upd | (flag_q & ~bus.chg_clr);
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if ((sync2[i] == sw_q[i]) || upd[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
      end
   end

   assign bus.sw_o     = sw_q;
   assign bus.sw_rise  = rise_q;
   assign bus.sw_fall  = fall_q;
   assign bus.chg_flag = flag_q;
   assign bus.chg_any  = |flag_q;
endmodule
